// File: rtl/button_deb_multi.sv
// button_deb_multi: N-channel push-button debouncer sharing one 1 ms timebase.
// Each channel synchronises its pin (optionally inverted for active-low buttons),
// accepts a new level only after it has persisted for debounce_per_ms ms ticks,
// and derives press/release pulses, a toggle and a one-shot long-press pulse.
// Outputs are plain registered levels/pulses; there is no handshake.
module button_deb_multi #(
    parameter int            N               = 4,
    parameter int            clk_freq        = 95000,
    parameter int            debounce_per_ms = 20,
    parameter int            long_press_ms   = 1000,
    parameter logic [N-1:0]  invert_mask     = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] button_in,
    output logic [N-1:0] button_level,
    output logic [N-1:0] button_press,
    output logic [N-1:0] button_rel,
    output logic [N-1:0] button_toggle,
    output logic [N-1:0] long_press,
    output logic         ms_tick
);

    // Prescaler width; a 1-cycle tick still needs a 1-bit counter.
    localparam int PW = (clk_freq > 1) ? $clog2(clk_freq) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(clk_freq - 1);

    // Debounce counter only ever reaches debounce_per_ms-1 before clearing.
    localparam int DW = $clog2(debounce_per_ms + 1);
    localparam logic [DW-1:0] DC_LAST = DW'(debounce_per_ms - 1);

    logic [PW-1:0] presc;
    logic [N-1:0]  sync1;
    logic [N-1:0]  sync2;

    // Shared timebase: counts 0..clk_freq-1 and wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
        end else if (presc == PRESC_LAST) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // The tick is the last count of the prescaler, so it is 0 while in reset.
    assign ms_tick = (presc == PRESC_LAST);

    // Two-flop synchroniser; polarity fixed before the first flop so that
    // everything downstream sees 1 = pressed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= button_in ^ invert_mask;
            sync2 <= sync1;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_ch
        logic [DW-1:0] dc;
        logic          level_r;
        logic          press_r;
        logic          rel_r;
        logic          toggle_r;
        logic          mismatch;
        logic          accept;

        // Synchronised input disagrees with the accepted level.
        assign mismatch = (sync2[i] != level_r);
        // Last qualifying tick: the new level is taken this cycle.
        assign accept   = mismatch && ms_tick && (dc == DC_LAST);

        // Stability counter: any return to the accepted level restarts it.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                dc <= '0;
            end else if (!mismatch) begin
                dc <= '0;
            end else if (ms_tick) begin
                if (dc == DC_LAST) begin
                    dc <= '0;
                end else begin
                    dc <= dc + 1'b1;
                end
            end
        end

        // Accepted level plus its edge pulses and toggle, all updated together.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                level_r  <= 1'b0;
                press_r  <= 1'b0;
                rel_r    <= 1'b0;
                toggle_r <= 1'b0;
            end else begin
                press_r <= accept && sync2[i];
                rel_r   <= accept && !sync2[i];
                if (accept) begin
                    level_r <= sync2[i];
                end
                if (accept && sync2[i]) begin
                    toggle_r <= ~toggle_r;
                end
            end
        end

        assign button_level[i]  = level_r;
        assign button_press[i]  = press_r;
        assign button_rel[i]    = rel_r;
        assign button_toggle[i] = toggle_r;

        if (long_press_ms > 0) begin : g_lp
            localparam int HW = $clog2(long_press_ms + 1);
            localparam logic [HW-1:0] HC_MAX = HW'(long_press_ms);

            logic [HW-1:0] hc;
            logic          lp_r;

            // Hold timer saturates at HC_MAX so a held button fires only once.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    hc   <= '0;
                    lp_r <= 1'b0;
                end else begin
                    lp_r <= 1'b0;
                    if (!level_r) begin
                        hc <= '0;
                    end else if (ms_tick && (hc < HC_MAX)) begin
                        hc   <= hc + 1'b1;
                        lp_r <= (hc == HC_MAX - 1'b1);
                    end
                end
            end

            assign long_press[i] = lp_r;
        end else begin : g_no_lp
            assign long_press[i] = 1'b0;
        end
    end

endmodule
